// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding and default timing constants for the
// key debounce bank.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } key_state_t;

   // Consecutive scan ticks needed before a level change is believed.
   localparam int STABLE_N_DEF = 20;
   // Scan ticks held in PRESSED before a long-press pulse.
   localparam int LONG_N_DEF   = 1000;

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: one key of the debounce bank. Synchronises the raw
// active-low key, runs the four-state debounce FSM on scan ticks and
// registers the clean level plus press/release pulses.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
module key_debounce_fsm
   import key_pkg::*;
#(
   parameter int STABLE_N = STABLE_N_DEF,
   parameter int CNT_W    = 5,
   parameter int LONG_N   = LONG_N_DEF,
   parameter int LONG_W   = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

   // Refuse to elaborate with counters too narrow for the requested thresholds.
   if (STABLE_N < 2 || STABLE_N >= (1 << CNT_W)) begin : g_bad_stable_n
      $error("key_debounce_fsm: STABLE_N does not fit in CNT_W bits");
   end
   if (LONG_N < 1 || LONG_N >= (1 << LONG_W)) begin : g_bad_long_n
      $error("key_debounce_fsm: LONG_N does not fit in LONG_W bits");
   end

   logic       sync1_q;
   logic       sync2_q;
   logic       kp;
   key_state_t state_q;
   logic [CNT_W-1:0] cnt_q;
   logic       level_q;
   logic       press_q;
   logic       release_q;

   // Two-flop synchroniser for the raw key; idles at "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

   assign kp = ~sync2_q;

   // Debounce FSM: moves only on scan ticks, pulses are one clk wide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (tick_i) begin
            case (state_q)
               IDLE: begin
                  if (kp) begin
                     state_q <= PRESS_CHK;
                     cnt_q   <= CNT_ONE;
                  end
               end
               PRESS_CHK: begin
                  if (!kp) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               PRESSED: begin
                  if (!kp) begin
                     state_q <= RELEASE_CHK;
                     cnt_q   <= CNT_ONE;
                  end
               end
               RELEASE_CHK: begin
                  if (kp) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q   <= IDLE;
                     cnt_q     <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

`ifdef KEY_LONG_PRESS_EN
   localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);
   localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_N);
   localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_N - 1);

   logic [LONG_W-1:0] long_cnt_q;
   logic              long_q;

   // Hold-time counter: cleared on accepted press or release, counts ticks
   // spent steadily in PRESSED, frozen in RELEASE_CHK, saturates at LONG_N.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (tick_i) begin
            if (state_q == PRESS_CHK && kp && cnt_q == CNT_LAST) begin
               long_cnt_q <= '0;
            end else if (state_q == RELEASE_CHK && !kp && cnt_q == CNT_LAST) begin
               long_cnt_q <= '0;
            end else if (state_q == PRESSED && kp && long_cnt_q != LONG_MAX) begin
               long_cnt_q <= long_cnt_q + LONG_ONE;
               if (long_cnt_q == LONG_PRE) begin
                  long_q <= 1'b1;
               end
            end
         end
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: debounces KEY_N active-low push buttons. The upstream
// divider's clk_div is treated as data, synchronised and edge-detected into
// a one-clk scan tick shared by every per-key FSM.
// Define KEY_LONG_PRESS_EN to build the per-key long-press pulse logic.
module key_debounce_bank
   import key_pkg::*;
#(
   parameter int KEY_N    = 4,
   parameter int STABLE_N = STABLE_N_DEF,
   parameter int CNT_W    = 5,
   parameter int LONG_N   = LONG_N_DEF,
   parameter int LONG_W   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_div,
   input  logic [KEY_N-1:0] key_n,
   output logic [KEY_N-1:0] key_level,
   output logic [KEY_N-1:0] key_press,
   output logic [KEY_N-1:0] key_release,
   output logic [KEY_N-1:0] key_long
);

   logic s1_q;
   logic s2_q;
   logic s3_q;
   logic tick_d;
   logic tick_q;

   assign tick_d = s2_q & ~s3_q;

   // Synchronise clk_div and register a single-clk pulse on each rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         s1_q   <= clk_div;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         tick_q <= tick_d;
      end
   end

   for (genvar gi = 0; gi < KEY_N; gi++) begin : g_key
      key_debounce_fsm #(
         .STABLE_N (STABLE_N),
         .CNT_W    (CNT_W),
         .LONG_N   (LONG_N),
         .LONG_W   (LONG_W)
      ) u_fsm (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick_i    (tick_q),
         .key_n_i   (key_n[gi]),
         .level_o   (key_level[gi]),
         .press_o   (key_press[gi]),
         .release_o (key_release[gi]),
         .long_o    (key_long[gi])
      );
   end

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank: directed scenarios for the key debounce bank with a
// run-length debounce model checked against the outputs every clk, plus
// hand-computed latency and pulse-count expectations.
module tb_key_debounce_bank;

   localparam int KEY_N    = 4;
   localparam int STABLE_N = 4;
   localparam int CNT_W    = 5;
   localparam int LONG_N   = 8;
   localparam int LONG_W   = 10;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             clk_div = 1'b0;
   logic [KEY_N-1:0] key_n   = '0;
   logic [KEY_N-1:0] key_level;
   logic [KEY_N-1:0] key_press;
   logic [KEY_N-1:0] key_release;
   logic [KEY_N-1:0] key_long;

   int n_checks = 0;
   int n_fail   = 0;
   bit done     = 1'b0;

   key_debounce_bank #(
      .KEY_N    (KEY_N),
      .STABLE_N (STABLE_N),
      .CNT_W    (CNT_W),
      .LONG_N   (LONG_N),
      .LONG_W   (LONG_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_div     (clk_div),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   initial forever #5 clk = ~clk;

   // Upstream even divider, DIV=20: toggles every 10 clk, held low in reset.
   int div_cnt = 0;
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         div_cnt = 0;
         clk_div = 1'b0;
      end else if (div_cnt == 9) begin
         div_cnt = 0;
         clk_div = ~clk_div;
      end else begin
         div_cnt++;
      end
   end

   // ---------------- behavioural model ----------------
   // Sample pipelines: clk_div reaches the FSM 3 clk after capture, keys 2 clk.
   bit [2:0]       m_div;
   bit             m_tick;
   bit [KEY_N-1:0] m_kn1, m_kn2;
   int             run [KEY_N];   // consecutive samples disagreeing with level
   bit             lvl [KEY_N];   // accepted level, 1 = pressed
`ifdef KEY_LONG_PRESS_EN
   int             longc [KEY_N];
`endif
   bit [KEY_N-1:0] exp_level, exp_press, exp_release, exp_long;
   int             cyc = 0;
   int             cap_cyc = 0;
   bit             seen_rise = 1'b0;

   task automatic model_reset();
      m_div = '0; m_tick = 1'b0; m_kn1 = '1; m_kn2 = '1;
      exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
      seen_rise = 1'b0;
      for (int k = 0; k < KEY_N; k++) begin
         run[k] = 0; lvl[k] = 1'b0;
`ifdef KEY_LONG_PRESS_EN
         longc[k] = 0;
`endif
      end
   endtask

   task automatic model_step();
      bit [KEY_N-1:0] kp;
      bit s;
      kp = ~m_kn2;
      exp_press = '0; exp_release = '0; exp_long = '0;
      if (m_tick) begin
         for (int k = 0; k < KEY_N; k++) begin
            s = kp[k];
`ifdef KEY_LONG_PRESS_EN
            if (lvl[k] && run[k] == 0 && s && longc[k] < LONG_N) begin
               longc[k]++;
               if (longc[k] == LONG_N) exp_long[k] = 1'b1;
            end
`endif
            if (s != lvl[k]) begin
               run[k]++;
               if (run[k] == STABLE_N) begin
                  lvl[k] = s;
                  run[k] = 0;
`ifdef KEY_LONG_PRESS_EN
                  longc[k] = 0;
`endif
                  if (s) exp_press[k] = 1'b1;
                  else   exp_release[k] = 1'b1;
               end
            end else begin
               run[k] = 0;
            end
         end
      end
      for (int k = 0; k < KEY_N; k++) exp_level[k] = lvl[k];
      m_tick = m_div[1] & ~m_div[2];
      m_div  = {m_div[1:0], clk_div};
      m_kn2  = m_kn1;
      m_kn1  = key_n;
      if (clk_div && !seen_rise) begin
         seen_rise = 1'b1;
         cap_cyc   = cyc;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            cyc++;
            model_step();
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check_vec(input string name, input logic [KEY_N-1:0] act,
                            input logic [KEY_N-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   int press_cnt [KEY_N];
   int rel_cnt   [KEY_N];
   int long_cnt  [KEY_N];
   int press_cyc [KEY_N];
   int rel_cyc   [KEY_N];
   int long_cyc  [KEY_N];

   task automatic clear_obs();
      for (int k = 0; k < KEY_N; k++) begin
         press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
         press_cyc[k] = 0; rel_cyc[k] = 0; long_cyc[k] = 0;
      end
   endtask

   // Compare every output against the model on each falling edge.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (done) break;
         check_vec("key_level",   key_level,   exp_level);
         check_vec("key_press",   key_press,   exp_press);
         check_vec("key_release", key_release, exp_release);
         check_vec("key_long",    key_long,    exp_long);
         for (int k = 0; k < KEY_N; k++) begin
            if (key_press[k] === 1'b1)   begin press_cnt[k]++; press_cyc[k] = cyc; end
            if (key_release[k] === 1'b1) begin rel_cnt[k]++;   rel_cyc[k]   = cyc; end
            if (key_long[k] === 1'b1)    begin long_cnt[k]++;  long_cyc[k]  = cyc; end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time budget exceeded, n_fail=%0d", n_fail);
      $fatal(1, "timeout");
   end

   // Hold a key pattern for n scan ticks; called at a clk_div rise.
   task automatic drive(input logic [KEY_N-1:0] kn, input int n);
      key_n = kn;
      repeat (n) @(posedge clk_div);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      clear_obs();
      // All keys held through reset: outputs stay 0 until release.
      key_n = '0;
      rst_n = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clk_div);
      for (int k = 0; k < KEY_N; k++) check_int("reset_hold_press_count", press_cnt[k], 1);
      // capture E1 -> tick after E1+2 -> FSM ticks at E1+3,+23,+43,+63
      check_int("first_press_latency", press_cyc[0] - cap_cyc, 63);
      drive(4'b1111, 6);
      for (int k = 0; k < KEY_N; k++) check_int("reset_hold_release_count", rel_cnt[k], 1);

      // Clean press on key0 for 6 ticks, then release.
      clear_obs();
      drive(4'b1110, 6);
      check_int("clean_press_count", press_cnt[0], 1);
      drive(4'b1111, 6);
      check_int("clean_release_count", rel_cnt[0], 1);
      check_int("clean_press_to_release", rel_cyc[0] - press_cyc[0], 120);

      // Bounce: 3 pressed, 1 released, 4 pressed.
      clear_obs();
      drive(4'b1110, 3);
      check_int("bounce_no_early_press", press_cnt[0], 0);
      drive(4'b1111, 1);
      drive(4'b1110, 4);
      check_int("bounce_single_press", press_cnt[0], 1);
      drive(4'b1111, 6);
      check_int("bounce_release_count", rel_cnt[0], 1);

      // Keys 1 and 2 together for 10 ticks.
      clear_obs();
      drive(4'b1001, 10);
      check_int("dual_press_k1", press_cnt[1], 1);
      check_int("dual_press_k2", press_cnt[2], 1);
      check_int("dual_press_same_clk", press_cyc[1] - press_cyc[2], 0);
      drive(4'b1111, 6);
      check_int("dual_release_k1", rel_cnt[1], 1);
      check_int("dual_release_k2", rel_cnt[2], 1);
      check_int("dual_release_same_clk", rel_cyc[1] - rel_cyc[2], 0);
      check_int("dual_press_to_release", rel_cyc[1] - press_cyc[1], 200);
      check_int("dual_idle_k0", press_cnt[0] + press_cnt[3], 0);

      // Long hold on key0 for 20 ticks.
      clear_obs();
      drive(4'b1110, 20);
`ifdef KEY_LONG_PRESS_EN
      check_int("long_count", long_cnt[0], 1);
      check_int("long_after_press", long_cyc[0] - press_cyc[0], 160);
`else
      check_int("long_absent", long_cnt[0], 0);
`endif
      drive(4'b1111, 6);
`ifdef KEY_LONG_PRESS_EN
      check_int("long_once_per_press", long_cnt[0], 1);
`else
      check_int("long_absent_after_release", long_cnt[0], 0);
`endif

      // Reset while key3 sits in PRESS_CHK with two samples counted.
      clear_obs();
      drive(4'b0111, 2);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_int("midreset_no_press", press_cnt[3], 0);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clk_div);
      check_int("midreset_press_count", press_cnt[3], 1);
      check_int("midreset_fresh_count", press_cyc[3] - cap_cyc, 63);
      drive(4'b1111, 6);
      check_int("midreset_release_count", rel_cnt[3], 1);

      done = 1'b1;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
